// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------
// sc_pkg : shared types and helpers for the stochastic adder tree
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package sc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } cnt_state_e;

  // Smallest r with 2**r >= v; usable in constant (parameter) context.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_toggle_adder.sv
// ---------------------------------------------------------------
// sc_toggle_adder : two-input stochastic scaled adder using a toggle bit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module sc_toggle_adder (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic out
);

  logic t_q;

  // Agreeing inputs pass straight through; disagreeing inputs alternate 0/1.
  assign out = (a == b) ? a : t_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q <= 1'b0;
    end else if (en && (a != b)) begin
      t_q <= ~t_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alaghi_adder_tree.sv
// ---------------------------------------------------------------
// alaghi_adder_tree : pipelined toggle-adder tree producing sum/P bitstream,
//                     plus a windowed ones counter on the output stream
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module alaghi_adder_tree
  import sc_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     x,
  input  logic             in_valid,
  output logic             out,
  output logic             out_valid,
  input  logic             start,
  input  logic [CNT_W-1:0] sample_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_out
);

  localparam int D = clog2(N);
  localparam int P = 1 << D;

  // Tree nodes are heap-indexed: root at 0, children of i at 2i+1 / 2i+2,
  // leaves (combinational, padded with zeros) at heap index P-1+j.
  logic [P-1:0] leaf;
  logic [P-2:0] node_q;
  logic [P-2:0] node_d;
  logic [P-2:0] node_en;
  logic [D-1:0] vld_q;

  always_comb begin
    leaf        = '0;
    leaf[N-1:0] = x;
  end

  generate
    for (genvar k = 1; k <= D; k++) begin : g_lvl
      for (genvar j = 0; j < (P >> k); j++) begin : g_cell
        localparam int IDX = (1 << (D - k)) - 1 + j;
        logic a;
        logic b;
        logic en;

        if (k == 1) begin : g_leaf
          assign a  = leaf[2*j];
          assign b  = leaf[2*j+1];
          assign en = in_valid;
        end else begin : g_inner
          assign a  = node_q[2*IDX+1];
          assign b  = node_q[2*IDX+2];
          assign en = vld_q[k-2];
        end

        assign node_en[IDX] = en;

        sc_toggle_adder u_cell (
          .clk (clk),
          .rst (rst),
          .en  (en),
          .a   (a),
          .b   (b),
          .out (node_d[IDX])
        );
      end
    end
  endgenerate

  // Level registers only capture on their input valid so gaps leave state intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      node_q <= '0;
      vld_q  <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < D; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int i = 0; i < P - 1; i++) begin
        if (node_en[i]) node_q[i] <= node_d[i];
      end
    end
  end

  assign out       = node_q[0];
  assign out_valid = vld_q[D-1];

  cnt_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] seen_inc;

  assign seen_inc = seen_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    seen_d  = seen_q;
    ones_d  = ones_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (start) begin
      // A new start always wins, aborting any window in progress.
      if (sample_len == '0) begin
        count_d = '0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_COUNT;
        len_d   = sample_len;
        seen_d  = '0;
        ones_d  = '0;
      end
    end else if ((state_q == ST_COUNT) && out_valid) begin
      seen_d = seen_inc;
      if (out && (ones_q != {CNT_W{1'b1}})) begin
        ones_d = ones_q + CNT_W'(1);
      end
      if (seen_inc == len_q) begin
        count_d = ones_d;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      seen_q  <= '0;
      ones_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      seen_q  <= seen_d;
      ones_q  <= ones_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == ST_COUNT);
  assign done      = done_q;
  assign count_out = count_q;

endmodule

`default_nettype wire
